// File: rtl/muxn_scan.sv
// muxn_scan: N-channel registered multiplexer with auto-scan, dwell timer, hold and wrap pulse.
module muxn_scan #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH),
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] i_din,
    input  logic [SELW-1:0]      i_sel,
    input  logic                 i_mode,
    input  logic                 i_hold,
    output logic [WIDTH-1:0]     o_dout,
    output logic [SELW-1:0]      o_ch_out,
    output logic                 o_valid,
    output logic                 o_wrap
);
    localparam int CW = $clog2(DWELL + 1);
    localparam logic [SELW-1:0] LAST = SELW'(NCH - 1);
    localparam logic [CW-1:0] DLAST = CW'(DWELL - 1);

    logic [SELW-1:0]  r_ptr, w_ptr_nxt, w_ch_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_mode_prev, w_entry, w_adv, w_wrap_nxt;
    logic [WIDTH-1:0] w_dout_nxt;

    // dout follows the pointer value being loaded, so every channel gets a full dwell
    always_comb begin
        w_entry    = i_mode & ~r_mode_prev;
        w_adv      = r_cnt == DLAST;
        w_ptr_nxt  = !i_mode ? r_ptr
                   : w_entry ? (int'(i_sel) < NCH ? i_sel : '0)
                   : !w_adv ? r_ptr
                   : r_ptr == LAST ? '0 : r_ptr + SELW'(1);
        w_cnt_nxt  = !i_mode ? r_cnt : (w_entry | w_adv) ? '0 : r_cnt + CW'(1);
        w_wrap_nxt = i_mode & ~w_entry & w_adv & (r_ptr == LAST);
        w_ch_nxt   = i_mode ? w_ptr_nxt : i_sel;
        w_dout_nxt = '0;
        for (int k = 0; k < NCH; k++)
            if (w_ch_nxt == SELW'(k)) w_dout_nxt = i_din[k*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_dout      <= '0;
            o_ch_out    <= '0;
            o_valid     <= 1'b0;
            o_wrap      <= 1'b0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_mode_prev <= 1'b0;
        end else if (i_hold) begin
            o_wrap <= 1'b0;
        end else begin
            o_dout      <= w_dout_nxt;
            o_ch_out    <= w_ch_nxt;
            o_valid     <= 1'b1;
            o_wrap      <= w_wrap_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mode_prev <= i_mode;
        end
    end
endmodule

// File: tb/tb_muxn_scan.sv
// tb_muxn_scan: three muxn_scan configurations checked against a sweep-position model.
module tb_muxn_scan;
    localparam int NC [3] = '{4, 5, 3};
    localparam int DW [3] = '{3, 2, 1};

    logic clk = 0, rst = 1, mode = 0, hold = 0;
    logic [2:0] sel = 0;
    logic [7:0] dch [3][5];
    logic [31:0] din0;
    logic [39:0] din1;
    logic [23:0] din2;
    logic [7:0] dout0, dout1, dout2;
    logic [1:0] ch0, ch2;
    logic [2:0] ch1;
    logic v0, v1, v2, w0, w1, w2;

    always_comb begin
        for (int k = 0; k < 4; k++) din0[k*8 +: 8] = dch[0][k];
        for (int k = 0; k < 5; k++) din1[k*8 +: 8] = dch[1][k];
        for (int k = 0; k < 3; k++) din2[k*8 +: 8] = dch[2][k];
    end

    muxn_scan #(.WIDTH(8), .NCH(4), .SELW(2), .DWELL(3)) u0 (
        .clk(clk), .rst(rst), .i_din(din0), .i_sel(sel[1:0]), .i_mode(mode), .i_hold(hold),
        .o_dout(dout0), .o_ch_out(ch0), .o_valid(v0), .o_wrap(w0));
    muxn_scan #(.WIDTH(8), .NCH(5), .SELW(3), .DWELL(2)) u1 (
        .clk(clk), .rst(rst), .i_din(din1), .i_sel(sel), .i_mode(mode), .i_hold(hold),
        .o_dout(dout1), .o_ch_out(ch1), .o_valid(v1), .o_wrap(w1));
    muxn_scan #(.WIDTH(8), .NCH(3), .SELW(2), .DWELL(1)) u2 (
        .clk(clk), .rst(rst), .i_din(din2), .i_sel(sel[1:0]), .i_mode(mode), .i_hold(hold),
        .o_dout(dout2), .o_ch_out(ch2), .o_valid(v2), .o_wrap(w2));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Model: a scan is a count t of non-hold cycles since entry; channel = start + t/DWELL mod NCH
    bit m_scan [3];
    int m_start [3], m_t [3], e_ch [3];
    logic [7:0] e_dout [3];
    bit e_valid [3], e_wrap [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            automatic int n = NC[i];
            automatic int d = DW[i];
            automatic int s = (i == 1) ? int'(sel) : int'(sel[1:0]);
            if (rst) begin
                e_dout[i] = 0; e_ch[i] = 0; e_valid[i] = 0; e_wrap[i] = 0; m_scan[i] = 0;
            end else if (hold) begin
                e_wrap[i] = 0;
            end else begin
                e_valid[i] = 1;
                e_wrap[i] = 0;
                if (!mode) begin
                    m_scan[i] = 0;
                    e_ch[i] = s;
                    e_dout[i] = (s < n) ? dch[i][s] : 8'h00;
                end else begin
                    if (!m_scan[i]) begin
                        m_scan[i] = 1;
                        m_start[i] = (s < n) ? s : 0;
                        m_t[i] = 0;
                    end else m_t[i]++;
                    e_ch[i] = (m_start[i] + m_t[i] / d) % n;
                    e_wrap[i] = m_t[i] > 0 && m_t[i] % d == 0 && e_ch[i] == 0;
                    e_dout[i] = dch[i][e_ch[i]];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("dout%0d", i), i == 0 ? dout0 : i == 1 ? dout1 : dout2, e_dout[i]);
                chk($sformatf("ch%0d", i), i == 0 ? {1'b0, ch0} : i == 1 ? ch1 : {1'b0, ch2}, e_ch[i]);
                chk($sformatf("valid%0d", i), i == 0 ? v0 : i == 1 ? v1 : v2, e_valid[i]);
                chk($sformatf("wrap%0d", i), i == 0 ? w0 : i == 1 ? w1 : w2, e_wrap[i]);
            end
        end
    end

    logic [7:0] man_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] scan_exp [9] = '{8'h33, 8'h33, 8'h33, 8'h44, 8'h44, 8'h44, 8'h11, 8'h11, 8'h11};
    bit wrap_exp [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    int ch2_exp [9] = '{2, 0, 1, 2, 0, 1, 2, 0, 1};
    bit w2_exp [9] = '{0, 1, 0, 0, 1, 0, 0, 1, 0};

    initial begin
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 5; k++) dch[i][k] = 8'($urandom);
        tick();
        chk_en = 1;
        tick();
        chk("rst_dout", dout0, 0);
        chk("rst_ch", ch0, 0);
        chk("rst_valid", v0, 0);
        chk("rst_wrap", w0, 0);
        for (int k = 0; k < 4; k++) dch[0][k] = man_exp[k];
        rst = 0;
        for (int s = 0; s < 4; s++) begin
            sel = 3'(s);
            tick();
            chk("man_dout", dout0, man_exp[s]);
            chk("man_ch", ch0, s);
            chk("man_valid", v0, 1);
        end
        sel = 6;
        tick();
        chk("oor_dout", dout1, 0);
        chk("oor_ch", ch1, 6);
        chk("oor_valid", v1, 1);
        sel = 2;
        mode = 1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("scan_dout", dout0, scan_exp[k]);
            chk("scan_wrap", w0, wrap_exp[k]);
            chk("d1_ch", ch2, ch2_exp[k]);
            chk("d1_wrap", w2, w2_exp[k]);
        end
        tick();
        chk("pre_hold1", dout0, 8'h22);
        tick();
        chk("pre_hold2", dout0, 8'h22);
        hold = 1;
        repeat (5) begin
            tick();
            chk("hold_dout", dout0, 8'h22);
            chk("hold_wrap", w0, 0);
        end
        hold = 0;
        tick();
        chk("post_hold22", dout0, 8'h22);
        tick();
        chk("post_hold33", dout0, 8'h33);
        rst = 1;
        tick();
        chk("mid_rst_dout", dout0, 0);
        chk("mid_rst_valid", v0, 0);
        rst = 0;
        sel = 1;
        repeat (3) begin
            tick();
            chk("restart22", dout0, 8'h22);
            chk("restart_ch", ch0, 1);
        end
        tick();
        chk("restart33", dout0, 8'h33);
        repeat (3000) begin
            rst = $urandom_range(0, 99) < 2;
            hold = $urandom_range(0, 99) < 15;
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            sel = 3'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++)
                for (int k = 0; k < 5; k++) dch[i][k] = 8'($urandom);
            tick();
        end
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
